// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared FSM state and owner encodings for the memory arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Requester and memory-bus signals of the fetch/data memory arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_rdata;
    logic          inst_ok;

    logic          data_req;
    logic          data_wr;
    logic [3:0]    data_wstrb;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic [DW-1:0] data_rdata;
    logic          data_ok;

    logic          mem_req;
    logic          mem_wr;
    logic [3:0]    mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_addr_ok;
    logic          mem_data_ok;
    logic [DW-1:0] mem_rdata;

    modport master (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output inst_rdata, inst_ok, data_rdata, data_ok,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
    );

    modport slave (
        output inst_req, inst_addr,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  inst_rdata, inst_ok, data_rdata, data_ok,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
    );

endinterface

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// Module   : mem_arb_pick
// Brief    : Combinational grant select; round-robin when MEM_ARB_RR_EN is
//            defined, fixed data priority otherwise.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  wire logic inst_req,
    input  wire logic data_req,
    input  wire logic last_owner,
    output logic      grant,
    output logic      any_req
);

    assign any_req = inst_req | data_req;

`ifdef MEM_ARB_RR_EN
    // On contention the owner that did not win last time gets the bus.
    always_comb begin
        grant = OWN_INST;
        if (inst_req && data_req) begin
            grant = ~last_owner;
        end else if (data_req) begin
            grant = OWN_DATA;
        end
    end
`else
    logic w_unused_last_owner;
    assign w_unused_last_owner = last_owner;

    always_comb begin
        grant = data_req ? OWN_DATA : OWN_INST;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one SRAM-like bus between fetch and data, one transaction
//            at a time. Optional round-robin grant via MEM_ARB_RR_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input wire logic      clk,
    input wire logic      rst,
    mem_arbiter_if.master bus
);

    logic [1:0]    r_state;
    logic          r_owner;
    logic          r_wr;
    logic [3:0]    r_wstrb;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_inst_rdata;
    logic [DW-1:0] r_data_rdata;

    logic          w_grant;
    logic          w_any_req;
    logic          w_capture;

    // r_owner doubles as the last-granted owner for the round-robin picker.
    mem_arb_pick u_pick (
        .inst_req   (bus.inst_req),
        .data_req   (bus.data_req),
        .last_owner (r_owner),
        .grant      (w_grant),
        .any_req    (w_any_req)
    );

    always_comb begin
        w_capture = 1'b0;
        if (r_state == ADDR) begin
            w_capture = bus.mem_addr_ok & bus.mem_data_ok;
        end else if (r_state == DATA) begin
            w_capture = bus.mem_data_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= OWN_DATA;
            r_wr         <= 1'b0;
            r_wstrb      <= 4'b0000;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_grant;
                        r_state <= ADDR;
                        if (w_grant == OWN_DATA) begin
                            r_wr    <= bus.data_wr;
                            r_wstrb <= bus.data_wstrb;
                            r_addr  <= bus.data_addr;
                            r_wdata <= bus.data_wdata;
                        end else begin
                            r_wr    <= 1'b0;
                            r_wstrb <= 4'b0000;
                            r_addr  <= bus.inst_addr;
                            r_wdata <= '0;
                        end
                    end
                end
                ADDR: begin
                    if (bus.mem_addr_ok) begin
                        r_state <= bus.mem_data_ok ? DONE : DATA;
                    end
                end
                DATA: begin
                    if (bus.mem_data_ok) begin
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Stores complete without disturbing the last load result.
            if (w_capture) begin
                if (r_owner == OWN_INST) begin
                    r_inst_rdata <= bus.mem_rdata;
                end else if (!r_wr) begin
                    r_data_rdata <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_req    = (r_state == ADDR);
    assign bus.mem_wr     = r_wr;
    assign bus.mem_wstrb  = r_wstrb;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.inst_ok    = (r_state == DONE) && (r_owner == OWN_INST);
    assign bus.data_ok    = (r_state == DONE) && (r_owner == OWN_DATA);
    assign bus.inst_rdata = r_inst_rdata;
    assign bus.data_rdata = r_data_rdata;

endmodule

`default_nettype wire
